// File: rtl/ifid_hazard_stage_pkg.sv
// ---------------------------------------------------------------------------
// ifid_hazard_stage_pkg
// Shared types and constants for the IF/ID hazard stage: opcode values,
// instruction field positions, the default NOP word and the decoded
// source-field payload handed to the hazard detector.
// ---------------------------------------------------------------------------
package ifid_hazard_stage_pkg;

    localparam int unsigned XLEN              = 32;
    localparam int unsigned REG_W             = 5;
    localparam int unsigned OP_W              = 6;
    localparam int unsigned DEF_COUNT_WIDTH   = 16;

    // Instruction field slice positions
    localparam int unsigned OP_MSB = 31;
    localparam int unsigned OP_LSB = 26;
    localparam int unsigned RS_MSB = 25;
    localparam int unsigned RS_LSB = 21;
    localparam int unsigned RT_MSB = 20;
    localparam int unsigned RT_LSB = 16;

    typedef logic [XLEN-1:0]  word_t;
    typedef logic [OP_W-1:0]  opcode_t;
    typedef logic [REG_W-1:0] reg_idx_t;

    // Opcodes whose rt field is a source operand
    localparam opcode_t OP_RTYPE = 6'h00;
    localparam opcode_t OP_BEQ   = 6'h04;
    localparam opcode_t OP_BNE   = 6'h05;
    localparam opcode_t OP_SW    = 6'h2B;

    // Word loaded into IF/ID on reset or flush
    localparam word_t NOP_WORD_DEFAULT = 32'h0000_0000;

    // Source-operand view of the instruction held in IF/ID
    typedef struct packed {
        opcode_t  opcode;
        reg_idx_t rs;
        reg_idx_t rt;
    } src_fields_t;

    // True when the opcode reads rt as a source register
    function automatic logic uses_rt(input opcode_t op);
        return (op == OP_RTYPE) || (op == OP_BEQ) ||
               (op == OP_BNE)   || (op == OP_SW);
    endfunction

endpackage : ifid_hazard_stage_pkg

// File: rtl/ifid_hazard_stage_if.sv
// ---------------------------------------------------------------------------
// ifid_hazard_stage_if
// Bundle between fetch/EX feedback and the IF/ID hazard stage.
//   master : fetch side, drives PC+4, instruction and ID/EX/EX feedback,
//            receives the IF/ID contents, PC enable, bubble and counters.
//   slave  : the IF/ID hazard stage itself.
// ---------------------------------------------------------------------------
interface ifid_hazard_stage_if
    import ifid_hazard_stage_pkg::*;
#(
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) ();

    // Fetch / pipeline feedback into the stage
    word_t                  pc_plus4_i;
    word_t                  instruction_i;
    logic                   idex_mem_read_i;
    reg_idx_t               idex_write_register_i;
    logic                   branch_taken_i;
    logic                   jmp_i;

    // Stage outputs
    word_t                  pc_o;
    word_t                  instruction_o;
    logic                   ifid_valid_o;
    logic                   pc_write_o;
    logic                   idex_bubble_o;
    logic [COUNT_WIDTH-1:0] stall_count_o;
    logic [COUNT_WIDTH-1:0] flush_count_o;

    modport master (
        output pc_plus4_i,
        output instruction_i,
        output idex_mem_read_i,
        output idex_write_register_i,
        output branch_taken_i,
        output jmp_i,
        input  pc_o,
        input  instruction_o,
        input  ifid_valid_o,
        input  pc_write_o,
        input  idex_bubble_o,
        input  stall_count_o,
        input  flush_count_o
    );

    modport slave (
        input  pc_plus4_i,
        input  instruction_i,
        input  idex_mem_read_i,
        input  idex_write_register_i,
        input  branch_taken_i,
        input  jmp_i,
        output pc_o,
        output instruction_o,
        output ifid_valid_o,
        output pc_write_o,
        output idex_bubble_o,
        output stall_count_o,
        output flush_count_o
    );

endinterface : ifid_hazard_stage_if

// File: rtl/ifid_hazard_stage_hazard_detect_unit.sv
// ---------------------------------------------------------------------------
// hazard_detect_unit
// Combinational load-use detector. Flags when the instruction in IF/ID
// reads a register that the load currently in ID/EX has yet to write.
//   i_fields              : opcode/rs/rt of the IF/ID instruction
//   i_ifid_valid          : IF/ID holds a real instruction
//   i_idex_mem_read       : ID/EX instruction is a load
//   i_idex_write_register : ID/EX destination register
//   o_load_use            : stall required this cycle
// ---------------------------------------------------------------------------
module hazard_detect_unit
    import ifid_hazard_stage_pkg::*;
(
    input  src_fields_t i_fields,
    input  logic        i_ifid_valid,
    input  logic        i_idex_mem_read,
    input  reg_idx_t    i_idex_write_register,
    output logic        o_load_use
);

    logic w_dest_nonzero;
    logic w_rs_match;
    logic w_rt_match;

    // $0 is hard-wired, so a load targeting it never creates a dependency
    assign w_dest_nonzero = (i_idex_write_register != '0);
    assign w_rs_match     = (i_idex_write_register == i_fields.rs);
    // rt is a destination for I-type loads/ALU ops; only match it when read
    assign w_rt_match     = uses_rt(i_fields.opcode) &&
                            (i_idex_write_register == i_fields.rt);

    assign o_load_use = i_ifid_valid & i_idex_mem_read & w_dest_nonzero &
                        (w_rs_match | w_rt_match);

endmodule : hazard_detect_unit

// File: rtl/ifid_hazard_stage.sv
// ---------------------------------------------------------------------------
// ifid_hazard_stage
// IF/ID pipeline register with load-use stall and EX-resolved flush.
//   clk    : rising-edge clock
//   reset  : asynchronous active-low reset
//   bus    : slave side of ifid_hazard_stage_if
//            in : pc_plus4_i, instruction_i, idex_mem_read_i,
//                 idex_write_register_i, branch_taken_i, jmp_i
//            out: pc_o, instruction_o, ifid_valid_o (registered),
//                 pc_write_o, idex_bubble_o (same-cycle),
//                 stall_count_o, flush_count_o (registered, saturating)
// ---------------------------------------------------------------------------
module ifid_hazard_stage
    import ifid_hazard_stage_pkg::*;
#(
    parameter word_t       NOP_WORD    = NOP_WORD_DEFAULT,
    parameter int unsigned COUNT_WIDTH = DEF_COUNT_WIDTH
) (
    input  logic                clk,
    input  logic                reset,
    ifid_hazard_stage_if.slave  bus
);

    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = '1;

    word_t                  r_pc;
    word_t                  r_instruction;
    logic                   r_valid;
    logic [COUNT_WIDTH-1:0] r_stall_count;
    logic [COUNT_WIDTH-1:0] r_flush_count;

    src_fields_t            w_fields;
    logic                   w_load_use;
    logic                   w_flush;
    logic                   w_stall_event;

    // Source operands of the instruction currently in IF/ID
    assign w_fields.opcode = r_instruction[OP_MSB:OP_LSB];
    assign w_fields.rs     = r_instruction[RS_MSB:RS_LSB];
    assign w_fields.rt     = r_instruction[RT_MSB:RT_LSB];

    hazard_detect_unit u_hazard_detect (
        .i_fields              (w_fields),
        .i_ifid_valid          (r_valid),
        .i_idex_mem_read       (bus.idex_mem_read_i),
        .i_idex_write_register (bus.idex_write_register_i),
        .o_load_use            (w_load_use)
    );

    assign w_flush       = bus.branch_taken_i | bus.jmp_i;
    // A flush discards the dependent instruction, so it is not a stall
    assign w_stall_event = w_load_use & ~w_flush;

    // Same-cycle control back to fetch and ID/EX
    assign bus.pc_write_o    = ~w_load_use | w_flush;
    assign bus.idex_bubble_o = w_load_use | w_flush;

    // IF/ID register: flush > load-use hold > advance
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pc          <= '0;
            r_instruction <= NOP_WORD;
            r_valid       <= 1'b0;
        end else if (w_flush) begin
            r_pc          <= '0;
            r_instruction <= NOP_WORD;
            r_valid       <= 1'b0;
        end else if (!w_load_use) begin
            r_pc          <= bus.pc_plus4_i;
            r_instruction <= bus.instruction_i;
            r_valid       <= 1'b1;
        end
    end

    // Saturating debug event counters
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_count <= '0;
            r_flush_count <= '0;
        end else begin
            if (w_stall_event && (r_stall_count != COUNT_MAX)) begin
                r_stall_count <= r_stall_count + COUNT_WIDTH'(1);
            end
            if (w_flush && (r_flush_count != COUNT_MAX)) begin
                r_flush_count <= r_flush_count + COUNT_WIDTH'(1);
            end
        end
    end

    assign bus.pc_o          = r_pc;
    assign bus.instruction_o = r_instruction;
    assign bus.ifid_valid_o  = r_valid;
    assign bus.stall_count_o = r_stall_count;
    assign bus.flush_count_o = r_flush_count;

endmodule : ifid_hazard_stage

// File: tb/tb_ifid_hazard_stage.sv
// ---------------------------------------------------------------------------
// tb_ifid_hazard_stage
// Directed, table-driven bench for ifid_hazard_stage plus hand-written
// sequences for reset/fill, async reset mid-stall and counter saturation.
// ---------------------------------------------------------------------------
module tb_ifid_hazard_stage;

    localparam int unsigned CW = 16;
    localparam int K_ADV   = 0;
    localparam int K_HOLD  = 1;
    localparam int K_FLUSH = 2;
    localparam logic [31:0] ADD_9_8 = 32'h0128_5020;

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic        mr;
        logic [4:0]  wr;
        logic        br;
        logic        jmp;
        int          kind;
    } vec_t;

    logic clk;
    logic reset;

    ifid_hazard_stage_if #(.COUNT_WIDTH(CW)) bus   ();
    ifid_hazard_stage_if #(.COUNT_WIDTH(CW)) bus_n ();

    ifid_hazard_stage #(.NOP_WORD(32'h0000_0000), .COUNT_WIDTH(CW)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Second instance whose NOP word has real source fields (rs=9, rt=8)
    ifid_hazard_stage #(.NOP_WORD(ADD_9_8), .COUNT_WIDTH(CW)) dut_nop (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int exp_stall = 0;
    int exp_flush = 0;
    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(input string name, input logic [31:0] instr, input logic mr,
                                input logic [4:0] wr, input logic br, input logic jmp, input int kind);
        vec_t v;
        v.name = name; v.instr = instr; v.mr = mr; v.wr = wr;
        v.br = br; v.jmp = jmp; v.kind = kind;
        return v;
    endfunction

    task automatic check_counts(input string tag);
        check({tag, "_stall_cnt"}, 32'(bus.stall_count_o), 32'(exp_stall));
        check({tag, "_flush_cnt"}, 32'(bus.flush_count_o), 32'(exp_flush));
    endtask

    initial begin
        logic [31:0] ld_pc, nx_pc, nx_instr, e_instr, e_pc;
        logic        e_valid;

        // add $10,$9,$8 / add $3,$0,$0 / lw $5,0($6) / sw $5,0($6)
        // beq $1,$2 / bne $1,$2 / addi $2,$1,5
        vecs[0]  = mk("add_rs_use",    ADD_9_8,      1, 9,  0, 0, K_HOLD);
        vecs[1]  = mk("add_rt_use",    ADD_9_8,      1, 8,  0, 0, K_HOLD);
        vecs[2]  = mk("add_no_load",   ADD_9_8,      0, 9,  0, 0, K_ADV);
        vecs[3]  = mk("add_other_dst", ADD_9_8,      1, 10, 0, 0, K_ADV);
        vecs[4]  = mk("dst_zero",      32'h0000_1820, 1, 0, 0, 0, K_ADV);
        vecs[5]  = mk("lw_rt_ignored", 32'h8CC5_0000, 1, 5, 0, 0, K_ADV);
        vecs[6]  = mk("lw_rs_use",     32'h8CC5_0000, 1, 6, 0, 0, K_HOLD);
        vecs[7]  = mk("sw_rt_use",     32'hACC5_0000, 1, 5, 0, 0, K_HOLD);
        vecs[8]  = mk("beq_rt_use",    32'h1022_0003, 1, 2, 0, 0, K_HOLD);
        vecs[9]  = mk("bne_rt_use",    32'h1422_0003, 1, 2, 0, 0, K_HOLD);
        vecs[10] = mk("addi_rt_dest",  32'h2022_0005, 1, 2, 0, 0, K_ADV);
        vecs[11] = mk("br_beats_stall", ADD_9_8,     1, 9,  1, 0, K_FLUSH);
        vecs[12] = mk("jmp_flush",     ADD_9_8,      0, 9,  0, 1, K_FLUSH);
        vecs[13] = mk("jmp_beats_lw",  32'h8CC5_0000, 1, 6, 0, 1, K_FLUSH);

        // Idle inputs; second instance sees a load to $9 throughout
        bus.pc_plus4_i = 32'h4;
        bus.instruction_i = ADD_9_8;
        bus.idex_mem_read_i = 1'b0;
        bus.idex_write_register_i = 5'd0;
        bus.branch_taken_i = 1'b0;
        bus.jmp_i = 1'b0;
        bus_n.pc_plus4_i = 32'h0;
        bus_n.instruction_i = 32'h0;
        bus_n.idex_mem_read_i = 1'b1;
        bus_n.idex_write_register_i = 5'd9;
        bus_n.branch_taken_i = 1'b0;
        bus_n.jmp_i = 1'b0;

        // ---- Reset values ----
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        check("rst_pc",     bus.pc_o, 32'h0);
        check("rst_instr",  bus.instruction_o, 32'h0);
        check("rst_valid",  32'(bus.ifid_valid_o), 32'h0);
        check("rst_pcw",    32'(bus.pc_write_o), 32'h1);
        check("rst_bubble", 32'(bus.idex_bubble_o), 32'h0);
        check_counts("rst");
        // Invalid IF/ID with matching fields must not stall
        check("nop_rst_instr",  bus_n.instruction_o, ADD_9_8);
        check("nop_invalid_pcw", 32'(bus_n.pc_write_o), 32'h1);
        check("nop_invalid_bub", 32'(bus_n.idex_bubble_o), 32'h0);

        // ---- Fill ----
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;
        check("fill_instr",  bus.instruction_o, ADD_9_8);
        check("fill_pc",     bus.pc_o, 32'h4);
        check("fill_valid",  32'(bus.ifid_valid_o), 32'h1);
        check("fill_pcw",    32'(bus.pc_write_o), 32'h1);
        check("fill_bubble", 32'(bus.idex_bubble_o), 32'h0);

        // ---- Table: preload IF/ID, apply hazard inputs, check both phases ----
        for (int i = 0; i < 14; i++) begin
            ld_pc    = 32'h0000_1000 + 32'(i) * 16;
            nx_pc    = 32'h0000_2000 + 32'(i) * 16;
            nx_instr = 32'hFC00_0000 | 32'(i);

            @(negedge clk);
            bus.instruction_i = vecs[i].instr;
            bus.pc_plus4_i = ld_pc;
            bus.idex_mem_read_i = 1'b0;
            bus.idex_write_register_i = 5'd0;
            bus.branch_taken_i = 1'b0;
            bus.jmp_i = 1'b0;
            @(posedge clk);

            @(negedge clk);
            bus.instruction_i = nx_instr;
            bus.pc_plus4_i = nx_pc;
            bus.idex_mem_read_i = vecs[i].mr;
            bus.idex_write_register_i = vecs[i].wr;
            bus.branch_taken_i = vecs[i].br;
            bus.jmp_i = vecs[i].jmp;
            #1;
            check({vecs[i].name, "_pcw"}, 32'(bus.pc_write_o),
                  (vecs[i].kind == K_HOLD) ? 32'h0 : 32'h1);
            check({vecs[i].name, "_bubble"}, 32'(bus.idex_bubble_o),
                  (vecs[i].kind == K_ADV) ? 32'h0 : 32'h1);

            case (vecs[i].kind)
                K_HOLD:  begin e_instr = vecs[i].instr; e_pc = ld_pc; e_valid = 1'b1; exp_stall++; end
                K_FLUSH: begin e_instr = 32'h0; e_pc = 32'h0; e_valid = 1'b0; exp_flush++; end
                default: begin e_instr = nx_instr; e_pc = nx_pc; e_valid = 1'b1; end
            endcase

            @(posedge clk); #1;
            check({vecs[i].name, "_instr"}, bus.instruction_o, e_instr);
            check({vecs[i].name, "_pc"},    bus.pc_o, e_pc);
            check({vecs[i].name, "_valid"}, 32'(bus.ifid_valid_o), 32'(e_valid));
            check_counts(vecs[i].name);
        end

        // ---- Async reset in the middle of a stall ----
        @(negedge clk);
        bus.instruction_i = ADD_9_8;
        bus.pc_plus4_i = 32'h40;
        bus.idex_mem_read_i = 1'b0;
        bus.branch_taken_i = 1'b0;
        bus.jmp_i = 1'b0;
        @(posedge clk);
        @(negedge clk);
        bus.idex_mem_read_i = 1'b1;
        bus.idex_write_register_i = 5'd9;
        @(posedge clk); #1;
        exp_stall++;
        check("ms_stall_pcw", 32'(bus.pc_write_o), 32'h0);
        check_counts("ms_pre");
        #2 reset = 1'b0;
        #1;
        exp_stall = 0;
        exp_flush = 0;
        check("ms_rst_pc",     bus.pc_o, 32'h0);
        check("ms_rst_instr",  bus.instruction_o, 32'h0);
        check("ms_rst_valid",  32'(bus.ifid_valid_o), 32'h0);
        check("ms_rst_pcw",    32'(bus.pc_write_o), 32'h1);
        check("ms_rst_bubble", 32'(bus.idex_bubble_o), 32'h0);
        check_counts("ms_rst");
        @(negedge clk);
        bus.idex_mem_read_i = 1'b0;
        bus.idex_write_register_i = 5'd0;
        reset = 1'b1;

        // ---- Flush counter saturation: 2^16 + 3 flush cycles ----
        @(negedge clk);
        bus.branch_taken_i = 1'b1;
        repeat (65534) @(posedge clk);
        #1;
        exp_flush = 65534;
        check_counts("sat_near");
        repeat (5) @(posedge clk);
        #1;
        exp_flush = 65535;
        check_counts("sat_final");
        check("sat_valid", 32'(bus.ifid_valid_o), 32'h0);
        @(negedge clk);
        bus.branch_taken_i = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_ifid_hazard_stage

// File: doc/ifid_hazard_stage.md
Name: ifid_hazard_stage

Overview:
- IF/ID pipeline stage with integrated load-use hazard detection and control-hazard flush. It sits between the fetch logic and the decoder / ID/EX register.
- It holds the fetched PC+4 and instruction, and stalls the PC and IF/ID on a load-use hazard. It flushes on a taken branch or jump resolved in EX.
- It drives a bubble request that zeroes the control fields entering ID/EX, and keeps saturating stall and flush event counters for debug.

Parameters:
- NOP_WORD, 32'h0000_0000, instruction word loaded into IF/ID on flush or reset.
- COUNT_WIDTH, 16, width of the stall and flush event counters.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- pc_plus4_i  input  32  PC+4 from fetch.
- instruction_i  input  32  instruction word from instruction memory.
- idex_mem_read_i  input  1  mem_read currently held in ID/EX.
- idex_write_register_i  input  5  destination register currently held in ID/EX.
- branch_taken_i  input  1  branch resolved taken in EX this cycle.
- jmp_i  input  1  jump in EX this cycle.
- pc_o  output  32  registered PC+4 to ID.
- instruction_o  output  32  registered instruction to ID.
- ifid_valid_o  output  1  IF/ID holds a real instruction.
- pc_write_o  output  1  PC update enable; 0 = hold PC.
- idex_bubble_o  output  1  1 = ID/EX must capture zeroed control fields.
- stall_count_o  output  COUNT_WIDTH  saturating count of stall cycles.
- flush_count_o  output  COUNT_WIDTH  saturating count of flush cycles.

Behaviour:
- Reset (reset=0, asynchronous): pc_o=0, instruction_o=NOP_WORD, ifid_valid_o=0, both counters=0. Combinational outputs follow from these values: pc_write_o=1, idex_bubble_o=0.
- Source fields decoded from instruction_o: rs=[25:21], rt=[20:16], opcode=[31:26].
- uses_rt is true for opcode 6'h00, 6'h04, 6'h05 and 6'h2B; false otherwise.
- load_use = ifid_valid_o & idex_mem_read_i & (idex_write_register_i != 0) & ((idex_write_register_i == rs) | (uses_rt & idex_write_register_i == rt)).
- flush = branch_taken_i | jmp_i.
- All of the following are combinational, same cycle:
  - pc_write_o = ~load_use | flush.
  - idex_bubble_o = load_use | flush.
- Register update, one per rising clk, in priority order:
  1. flush: instruction_o<=NOP_WORD, pc_o<=0, ifid_valid_o<=0. Flush overrides a simultaneous load_use.
  2. load_use: IF/ID holds all fields unchanged.
  3. otherwise: instruction_o<=instruction_i, pc_o<=pc_plus4_i, ifid_valid_o<=1.
- Latency: instruction_i to instruction_o is 1 cycle.
- A load-use stall lasts exactly 1 cycle in normal operation. The bubble clears idex_mem_read_i on the following cycle, so load_use deasserts with no extra state.
- Counters:
  - stall_count_o increments on each cycle with load_use & ~flush.
  - flush_count_o increments on each cycle with flush.
  - Both saturate at all-ones; they never wrap.
- A write to register $0 never causes a stall.
- An invalid IF/ID (after reset or flush) never causes a stall.
- Reset asserted mid-stall or mid-flush returns all registers to reset values immediately. There are no pending effects after reset release.

Decomposition:
- Shared package holds:
  - opcode constants: OP_RTYPE=6'h00, OP_BEQ=6'h04, OP_BNE=6'h05, OP_SW=6'h2B;
  - NOP_WORD default value;
  - field slice positions for rs and rt.
- One sub-module: hazard_detect_unit. It is purely combinational: inputs are the instruction fields, ifid_valid, idex_mem_read and idex_write_register; output is load_use.
- IF/ID storage, priority logic and counters live in the top-level module.

Test Plan:
- Reset and fill: release reset, instruction_i=32'h0128_5020 (add $10,$9,$8), pc_plus4_i=32'h4 -> next cycle instruction_o=32'h0128_5020, pc_o=4, ifid_valid_o=1, pc_write_o=1, idex_bubble_o=0.
- Load-use on rs: IF/ID holds add $10,$9,$8; idex_mem_read_i=1, idex_write_register_i=9 -> same cycle pc_write_o=0, idex_bubble_o=1; next cycle IF/ID unchanged, stall_count_o=1.
- rt ignored for lw: IF/ID holds lw $5,0($6) (opcode 6'h23), idex_write_register_i=5, idex_mem_read_i=1 -> no stall; a write register of $0 also gives no stall.
- Flush beats stall: load_use true and branch_taken_i=1 in the same cycle -> pc_write_o=1, idex_bubble_o=1; next cycle instruction_o=NOP_WORD, ifid_valid_o=0, flush_count_o=1, stall_count_o unchanged.
- Counter saturation: force 2^COUNT_WIDTH+3 flush cycles -> flush_count_o stays at 16'hFFFF.
- Async reset mid-stall: drop reset between clock edges during a stall -> outputs take reset values immediately, without waiting for a clock edge.
